// File: rtl/num_entry.sv
// rtl/num_entry.sv - keypad number entry with BCD-to-binary conversion; NUM_ENTRY_AUTOCOMMIT_EN commits a full entry without Enter
module num_entry #(
  parameter int DIGITS = 3,
  parameter int VAL_W  = 12
) (
  input  logic                  clk_div,
  input  logic                  rst,
  input  logic [3:0]            num,
  input  logic                  load_num,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [2:0]            digit_cnt,
  output logic                  neg,
  output logic                  busy,
  output logic [VAL_W-1:0]      value,
  output logic                  num_valid
);

  localparam int BW = 4 * DIGITS;
  localparam int AW = VAL_W - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_CONV,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            load_q;
  logic [AW-1:0]   acc_q, acc_d;
  logic [2:0]      step_q, step_d;
  logic [BW-1:0]   bcd_d;
  logic [2:0]      cnt_d;
  logic            neg_d;
  logic [VAL_W-1:0] value_d;
  logic            valid_d;

  logic            key_ok;
  logic            is_digit;
  logic [BW-1:0]   bcd_shift;
  logic [3:0]      cur_digit;
  logic [AW-1:0]   ten;
  logic [AW-1:0]   acc_next;
  logic [VAL_W-1:0] acc_ext;

  // Rising edge of the key-present level; codes 13-15 never count as keys.
  assign key_ok    = load_num && !load_q && (num <= 4'd12);
  assign is_digit  = (num <= 4'd9);
  assign bcd_shift = (bcd << 4) | BW'(num);
  assign ten       = AW'(10);
  assign acc_next  = (acc_q * ten) + AW'(cur_digit);
  assign acc_ext   = {1'b0, acc_q};
  assign busy      = (state_q == S_CONV);

  // Pick the digit for this conversion step; step counts down so the oldest digit goes first.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (step_q == 3'(i + 1)) cur_digit = bcd[4*i +: 4];
    end
  end

  // Next-state and datapath updates for the entry/convert FSM.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd;
    cnt_d   = digit_cnt;
    neg_d   = neg;
    acc_d   = acc_q;
    step_d  = step_q;
    value_d = value;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (key_ok) begin
          if (is_digit) begin
            if (digit_cnt < 3'(DIGITS)) begin
              bcd_d   = bcd_shift;
              cnt_d   = digit_cnt + 3'd1;
              state_d = S_ENTRY;
`ifdef NUM_ENTRY_AUTOCOMMIT_EN
              if (digit_cnt == 3'(DIGITS - 1)) begin
                state_d = S_CONV;
                step_d  = 3'(DIGITS);
                acc_d   = '0;
              end
`endif
            end
          end else if (num == 4'd10) begin
            neg_d   = !neg;
            state_d = S_ENTRY;
          end else if (num == 4'd11) begin
            state_d = S_CONV;
            step_d  = digit_cnt;
            acc_d   = '0;
          end else begin
            bcd_d   = '0;
            cnt_d   = 3'd0;
            neg_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      S_CONV: begin
        if (step_q == 3'd0) begin
          // Two's complement of zero is zero, so -0 cannot appear.
          value_d = neg ? (-acc_ext) : acc_ext;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d  = acc_next;
          step_d = step_q - 3'd1;
        end
      end

      S_DONE: begin
        if (key_ok) begin
          if (is_digit) begin
            bcd_d   = BW'(num);
            cnt_d   = 3'd1;
            neg_d   = 1'b0;
            state_d = S_ENTRY;
`ifdef NUM_ENTRY_AUTOCOMMIT_EN
            if (DIGITS == 1) begin
              state_d = S_CONV;
              step_d  = 3'd1;
              acc_d   = '0;
            end
`endif
          end else if (num == 4'd10) begin
            bcd_d   = '0;
            cnt_d   = 3'd0;
            neg_d   = 1'b1;
            state_d = S_ENTRY;
          end else if (num == 4'd11) begin
            state_d = S_CONV;
            step_d  = digit_cnt;
            acc_d   = '0;
          end else begin
            bcd_d   = '0;
            cnt_d   = 3'd0;
            neg_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any key seen on the same edge.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      state_q   <= S_IDLE;
      load_q    <= 1'b0;
      bcd       <= '0;
      digit_cnt <= 3'd0;
      neg       <= 1'b0;
      acc_q     <= '0;
      step_q    <= 3'd0;
      value     <= '0;
      num_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_num;
      bcd       <= bcd_d;
      digit_cnt <= cnt_d;
      neg       <= neg_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      value     <= value_d;
      num_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_num_entry.sv
// tb/tb_num_entry.sv - directed self-checking bench for num_entry
module tb_num_entry;

  logic        clk_div;
  logic        rst;
  logic [3:0]  num;
  logic        load_num;
  logic [11:0] bcd;
  logic [2:0]  digit_cnt;
  logic        neg;
  logic        busy;
  logic [11:0] value;
  logic        num_valid;

  int n_vec;
  int n_fail;
  int pulses;

  num_entry #(.DIGITS(3), .VAL_W(12)) dut (
    .clk_div   (clk_div),
    .rst       (rst),
    .num       (num),
    .load_num  (load_num),
    .bcd       (bcd),
    .digit_cnt (digit_cnt),
    .neg       (neg),
    .busy      (busy),
    .value     (value),
    .num_valid (num_valid)
  );

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  // Count result pulses, sampled just after each edge.
  always @(posedge clk_div) begin
    #1;
    if (num_valid === 1'b1) pulses++;
  end

  task automatic key(input logic [3:0] k);
    @(negedge clk_div);
    num = k;
    load_num = 1'b1;
    @(negedge clk_div);
    load_num = 1'b0;
  endtask

  task automatic do_enter(input int exp_lat, input logic [11:0] exp_val);
    int lat;
    @(negedge clk_div);
    num = 4'd11;
    load_num = 1'b1;
    @(posedge clk_div);
    #1;
    load_num = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL enter_busy: got %b expected 1", busy); n_fail++;
    end
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk_div);
      #1;
      if (num_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_vec++;
    if (lat !== exp_lat) begin
      $display("FAIL enter_latency: got %0d expected %0d", lat, exp_lat); n_fail++;
    end
    n_vec++;
    if (value !== exp_val) begin
      $display("FAIL enter_value: got %h expected %h", value, exp_val); n_fail++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      $display("FAIL enter_busy_drop: got %b expected 0", busy); n_fail++;
    end
    @(posedge clk_div);
    #1;
    n_vec++;
    if (num_valid !== 1'b0) begin
      $display("FAIL enter_pulse_width: got %b expected 0", num_valid); n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    num = 4'd0;
    load_num = 1'b0;
    repeat (3) @(posedge clk_div);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({bcd, digit_cnt, neg, busy, value, num_valid} !== 31'd0) begin
      $display("FAIL reset_state: got bcd=%h cnt=%0d neg=%b busy=%b value=%h valid=%b expected all 0",
               bcd, digit_cnt, neg, busy, value, num_valid);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    key(4'd1); key(4'd2); key(4'd3);
    n_vec++;
    if (bcd !== 12'h123 || digit_cnt !== 3'd3) begin
      $display("FAIL basic_entry: got bcd=%h cnt=%0d expected 123/3", bcd, digit_cnt); n_fail++;
    end
    do_enter(4, 12'h07B);
  endtask

  task automatic test_negative();
    key(4'd10); key(4'd4); key(4'd5);
    n_vec++;
    if (bcd !== 12'h045 || digit_cnt !== 3'd2 || neg !== 1'b1) begin
      $display("FAIL neg_entry: got bcd=%h cnt=%0d neg=%b expected 045/2/1", bcd, digit_cnt, neg); n_fail++;
    end
    do_enter(3, 12'hFD3);
    key(4'd10); key(4'd10);
    n_vec++;
    if (bcd !== 12'h000 || digit_cnt !== 3'd0 || neg !== 1'b0) begin
      $display("FAIL done_sign_restart: got bcd=%h cnt=%0d neg=%b expected 000/0/0", bcd, digit_cnt, neg); n_fail++;
    end
    do_enter(1, 12'h000);
  endtask

  task automatic test_hold();
    int p0;
    @(negedge clk_div);
    num = 4'd7;
    load_num = 1'b1;
    repeat (6) @(negedge clk_div);
    load_num = 1'b0;
    @(negedge clk_div);
    n_vec++;
    if (bcd !== 12'h007 || digit_cnt !== 3'd1 || neg !== 1'b0) begin
      $display("FAIL hold_single_key: got bcd=%h cnt=%0d neg=%b expected 007/1/0", bcd, digit_cnt, neg); n_fail++;
    end
    p0 = pulses;
    num = 4'd11;
    load_num = 1'b1;
    @(negedge clk_div);
    load_num = 1'b0;
    @(negedge clk_div);
    load_num = 1'b1;
    @(negedge clk_div);
    load_num = 1'b0;
    repeat (4) @(negedge clk_div);
    n_vec++;
    if (value !== 12'h007) begin
      $display("FAIL hold_value: got %h expected 007", value); n_fail++;
    end
    n_vec++;
    if (pulses - p0 !== 1) begin
      $display("FAIL busy_key_discard: got %0d pulses expected 1", pulses - p0); n_fail++;
    end
  endtask

  task automatic test_full();
    key(4'd12);
    key(4'd15);
    n_vec++;
    if (bcd !== 12'h000 || digit_cnt !== 3'd0) begin
      $display("FAIL ignored_code: got bcd=%h cnt=%0d expected 000/0", bcd, digit_cnt); n_fail++;
    end
    key(4'd9); key(4'd8); key(4'd7); key(4'd6);
    n_vec++;
    if (bcd !== 12'h987 || digit_cnt !== 3'd3) begin
      $display("FAIL full_entry: got bcd=%h cnt=%0d expected 987/3", bcd, digit_cnt); n_fail++;
    end
    do_enter(4, 12'h3DB);
    key(4'd12);
    n_vec++;
    if (bcd !== 12'h000 || digit_cnt !== 3'd0 || neg !== 1'b0 || busy !== 1'b0 || value !== 12'h3DB) begin
      $display("FAIL clear_after_done: got bcd=%h cnt=%0d neg=%b busy=%b value=%h expected 000/0/0/0/3db",
               bcd, digit_cnt, neg, busy, value);
      n_fail++;
    end
  endtask

  task automatic test_neg_zero();
    key(4'd10);
    do_enter(1, 12'h000);
    n_vec++;
    if (neg !== 1'b1) begin
      $display("FAIL neg_zero_sign_held: got %b expected 1", neg); n_fail++;
    end
  endtask

  task automatic test_reset_conv();
    int p0;
    key(4'd5);
    n_vec++;
    if (bcd !== 12'h005 || digit_cnt !== 3'd1 || neg !== 1'b0) begin
      $display("FAIL rc_entry: got bcd=%h cnt=%0d neg=%b expected 005/1/0", bcd, digit_cnt, neg); n_fail++;
    end
    p0 = pulses;
    @(negedge clk_div);
    num = 4'd11;
    load_num = 1'b1;
    @(posedge clk_div);
    #1;
    load_num = 1'b0;
    @(posedge clk_div);
    @(negedge clk_div);
    rst = 1'b1;
    @(posedge clk_div);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({bcd, digit_cnt, neg, busy, value, num_valid} !== 31'd0 || pulses != p0) begin
      $display("FAIL reset_mid_conv: got bcd=%h cnt=%0d neg=%b busy=%b value=%h valid=%b pulses=%0d expected all 0, pulses=%0d",
               bcd, digit_cnt, neg, busy, value, num_valid, pulses, p0);
      n_fail++;
    end
    @(negedge clk_div);
    num = 4'd3;
    load_num = 1'b1;
    rst = 1'b1;
    @(posedge clk_div);
    #1;
    rst = 1'b0;
    load_num = 1'b0;
    repeat (2) @(negedge clk_div);
    n_vec++;
    if (digit_cnt !== 3'd0 || bcd !== 12'h000) begin
      $display("FAIL reset_key_same_edge: got bcd=%h cnt=%0d expected 000/0", bcd, digit_cnt); n_fail++;
    end
  endtask

`ifdef NUM_ENTRY_AUTOCOMMIT_EN
  task automatic test_autocommit();
    int lat;
    key(4'd2); key(4'd0);
    @(negedge clk_div);
    num = 4'd1;
    load_num = 1'b1;
    @(posedge clk_div);
    #1;
    load_num = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL auto_busy: got %b expected 1", busy); n_fail++;
    end
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk_div);
      #1;
      if (num_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_vec++;
    if (lat !== 4) begin
      $display("FAIL auto_latency: got %0d expected 4", lat); n_fail++;
    end
    n_vec++;
    if (value !== 12'h0C9) begin
      $display("FAIL auto_value: got %h expected 0c9", value); n_fail++;
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_fail = 0;
    pulses = 0;
    rst = 1'b1;
    num = 4'd0;
    load_num = 1'b0;
    test_reset();
`ifdef NUM_ENTRY_AUTOCOMMIT_EN
    test_autocommit();
`else
    test_basic();
    test_negative();
    test_hold();
    test_full();
    test_neg_zero();
    test_reset_conv();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/num_entry.md
# num_entry

Keypad number-entry stage directly downstream of the matrix keypad scanner. Consumes the scanner's 4-bit key code and its `load_num` strobe, assembles up to `DIGITS` decimal digits plus a sign, and on Enter converts the entry to a two's-complement binary value. It outputs the value with a one-cycle valid pulse, and keeps live BCD/sign outputs available for the display path.

## Interface
- `DIGITS`, 3: maximum decimal digits per entry (1..4).
- `VAL_W`, 12: width of the signed result; must hold ±(10^DIGITS − 1).
- `clk_div` in 1: scan-domain clock, same clock as the keypad scanner.
- `rst` in 1: reset, synchronous, active-high.
- `num` in 4: key code from the scanner. 0–9 are digits, 10 (A) is sign toggle, 11 (B) is Enter, 12 (C) is Clear, 13–15 are ignored.
- `load_num` in 1: key-present level from the scanner. It may stay high for several cycles per press.
- `bcd` out 4*DIGITS: entered digits. Most recent digit is in `[3:0]`; unused digits read 0.
- `digit_cnt` out 3: number of digits entered, 0..DIGITS.
- `neg` out 1: current sign flag.
- `busy` out 1: high while in CONV.
- `value` out VAL_W: last committed signed result. Held until the next commit.
- `num_valid` out 1: one-cycle pulse when `value` updates.

## Operation
- Key acceptance: register `load_q <= load_num`. A key is accepted at a posedge where `load_num && !load_q`, using `num` sampled at that same edge. Holding `load_num` high yields exactly one key. Keys accepted while `busy` are discarded.
- FSM states:
  - **IDLE**: empty entry.
  - **ENTRY**: at least one digit or sign entered.
  - **CONV**: conversion in progress.
  - **DONE**: result committed.
- Digit 0–9 in IDLE or ENTRY:
  - If `digit_cnt < DIGITS`: shift `bcd` left 4 bits, insert the digit at `[3:0]`, increment `digit_cnt`, go to ENTRY.
  - Otherwise: ignore the digit, no state change.
  - Leading zeros count as digits.
- A: toggles `neg` in IDLE or ENTRY, then go to ENTRY.
- C: clears `bcd`, `digit_cnt` and `neg`, then go to IDLE. Valid from IDLE, ENTRY and DONE.
- B in IDLE or ENTRY: go to CONV and load a step counter with `digit_cnt`.
  - Each CONV cycle performs `acc <= acc*10 + next digit`, most significant entered digit first.
  - When the counter reaches 0: `value <= neg ? -acc : acc`, pulse `num_valid`, go to DONE.
  - B with `digit_cnt == 0` commits 0.
  - Result −0 is never produced: commit `value` = 0 regardless of `neg`.
- DONE: `bcd`, `digit_cnt` and `neg` are held for display.
  - A digit key first clears the entry, then applies the digit as the first digit (goes to ENTRY).
  - A clears the entry, then sets `neg`=1 (goes to ENTRY).
  - B re-commits the same entry through CONV.
  - C goes to IDLE.
- Keys 13–15 are ignored in every state, including for edge tracking (`load_q` still updates).
- Arithmetic: `acc` is unsigned, VAL_W−1 bits; negation is two's complement at VAL_W bits. With the default parameters no overflow is possible.

## Timing
- Reset values:
  - state IDLE
  - `bcd`=0, `digit_cnt`=0, `neg`=0
  - `value`=0, `num_valid`=0, `busy`=0
  - `load_q`=0
  - `acc`=0
- Key-to-output latency: an accepted key at edge k is visible on `bcd`/`digit_cnt`/`neg` after edge k (one register stage).
- Enter-to-result latency: B accepted at edge k, with n = `digit_cnt`:
  - `busy` is high after edge k.
  - `value` and `num_valid` update after edge k+n+1.
  - `busy` drops after that same edge.
  - B with n = 0 gives a result after edge k+1.
- `num_valid` is high for exactly one cycle.
- Reset mid-CONV: abort with no `num_valid`. `value` returns to 0.
- `rst` and a key edge at the same posedge: `rst` wins and the key is lost.

## Configuration
- `NUM_ENTRY_AUTOCOMMIT_EN` defined: accepting the DIGITS-th digit immediately enters CONV as if B were pressed. The result timing counts from that digit's edge, so the result appears after edge k+DIGITS+1. A later B in DONE re-commits.
- Undefined: a full entry waits for B; further digits are ignored.

## Test plan
- Keys 1,2,3,B (DIGITS=3, VAL_W=12) -> `bcd`=0x123, `value`=0x07B (123). `num_valid` is one cycle, exactly 4 edges after the B edge.
- Keys A,4,5,B -> `neg`=1, `value`=0xFD3 (−45). Then keys A,A,B in DONE -> new entry with `neg`=0, empty digits, commits 0.
- `load_num` held high for 6 cycles with `num`=7, then keys B -> single digit 7, `value`=7. Assert B during CONV -> ignored.
- Keys 9,8,7,6,B -> 6 ignored, `value`=987 (0x3DB). Then C -> `bcd`=0, `digit_cnt`=0, state IDLE, `value` still 987.
- Keys A,B -> `value`=0, not −0. Keys 5,B then `rst` asserted on the second CONV cycle -> no `num_valid`, all outputs at reset values.
- With `NUM_ENTRY_AUTOCOMMIT_EN`: keys 2,0,1 -> `value`=201 with `num_valid` 4 edges after the '1' edge, and no B pressed.
